// File: rtl/yabot_bus_pkg.sv
// Shared readback bus definitions: word layout, widths and channel indices.
package yabot_bus_pkg;
   localparam int RB_DATA_W = 28;
   localparam int RB_CTRL_W = 4;
   localparam int RB_ADDR_W = 4;

   localparam int CH_STATUS = 0;
   localparam int CH_SONAR  = 1;
   localparam int CH_MOTOR  = 2;
   localparam int CH_ADC    = 3;
   localparam int CH_RADIO  = 4;
   localparam int CH_RC     = 5;

   typedef struct packed {
      logic [RB_CTRL_W-1:0]           ctrl;
      logic [RB_DATA_W-RB_CTRL_W-1:0] data;
   } rb_word_t;
endpackage

// File: rtl/rb_fifo.sv
// Per-channel synchronous FIFO with registered not-full and drop indication.
module rb_fifo #(
   parameter int DATA_W = 28,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic              not_full,
   output logic              drop
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       cnt, cnt_nxt;
   logic              rdy_q;
   logic              push_ok, pop_ok;

   assign full     = (cnt == FULL_CNT);
   assign empty    = (cnt == '0);
   // A full FIFO still takes a push when the same cycle frees a slot.
   assign push_ok  = push && (!full || pop);
   assign pop_ok   = pop && !empty;
   assign drop     = push && full && !pop;
   assign rdata    = mem[rd_ptr];
   assign not_full = rdy_q;

   always_comb begin
      cnt_nxt = cnt;
      if (push_ok && !pop_ok)
         cnt_nxt = cnt + 1'b1;
      else if (pop_ok && !push_ok)
         cnt_nxt = cnt - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         rdy_q  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         cnt   <= cnt_nxt;
         rdy_q <= (cnt_nxt != FULL_CNT);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/readback_hub.sv
// Readback concentrator: per-channel FIFOs, round-robin arbiter, one output register.
// Define READBACK_HUB_PRIO_EN to give channel 0 (status) strict priority.
module readback_hub
   import yabot_bus_pkg::*;
#(
   parameter int N_CH       = 6,
   parameter int DATA_W     = RB_DATA_W,
   parameter int ADDR_W     = RB_ADDR_W,
   parameter int FIFO_DEPTH = 4,
   parameter int CH_BASE    = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_CH*DATA_W-1:0]   ch_data,
   input  logic [N_CH-1:0]          ch_wr,
   output logic [N_CH-1:0]          ch_rdy,
   output logic [DATA_W-1:0]        out_data,
   output logic [ADDR_W-1:0]        out_addr,
   output logic                     out_valid,
   input  logic                     out_rdy,
   output logic [N_CH-1:0]          ovf,
   input  logic [N_CH-1:0]          ovf_clr
);
   localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic {ST_EMPTY, ST_FULL} out_state_t;

   out_state_t        state, state_nxt;
   logic [DATA_W-1:0] fifo_rdata [N_CH];
   logic [N_CH-1:0]   fifo_full, fifo_empty, drop, pop, rr_req;
   logic [PTR_W-1:0]  ptr, ptr_nxt, gnt_idx, cand;
   logic              gnt_vld, load, grant;

   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int step);
      int sum;
      sum = int'(base) + step;
      if (sum >= N_CH) sum -= N_CH;
      return PTR_W'(sum);
   endfunction

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      rb_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk      (clk),
         .rst_n    (rst_n),
         .push     (ch_wr[i]),
         .pop      (pop[i]),
         .wdata    (ch_data[i*DATA_W +: DATA_W]),
         .rdata    (fifo_rdata[i]),
         .full     (fifo_full[i]),
         .empty    (fifo_empty[i]),
         .not_full (ch_rdy[i]),
         .drop     (drop[i])
      );
   end

   // Arbiter: first non-empty channel at or after ptr, wrapping.
   always_comb begin
      rr_req  = ~fifo_empty;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      ptr_nxt = ptr;
`ifdef READBACK_HUB_PRIO_EN
      rr_req[0] = 1'b0;
`endif
      for (int k = 0; k < N_CH; k++) begin
         cand = wrap_add(ptr, k);
         if (!gnt_vld && rr_req[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
            ptr_nxt = wrap_add(cand, 1);
         end
      end
`ifdef READBACK_HUB_PRIO_EN
      if (!fifo_empty[0]) begin
         gnt_vld = 1'b1;
         gnt_idx = '0;
         ptr_nxt = ptr;
      end
`endif
   end

   assign load      = (state == ST_EMPTY) || out_rdy;
   assign grant     = load && gnt_vld;
   assign pop       = grant ? (N_CH'(1) << gnt_idx) : '0;
   assign out_valid = (state == ST_FULL);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: if (gnt_vld) state_nxt = ST_FULL;
         ST_FULL:  if (out_rdy && !gnt_vld) state_nxt = ST_EMPTY;
         default:  state_nxt = ST_EMPTY;
      endcase
   end

   // Output register stage and sticky overflow flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_EMPTY;
         out_data <= '0;
         out_addr <= '0;
         ptr      <= '0;
         ovf      <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            out_data <= fifo_rdata[gnt_idx];
            out_addr <= ADDR_W'(CH_BASE) + ADDR_W'(gnt_idx);
            ptr      <= ptr_nxt;
         end
         ovf <= (ovf & ~ovf_clr) | drop;
      end
   end
endmodule

// File: tb/tb_readback_hub.sv
// Directed bench for readback_hub with a queue-based reference model checked every cycle.
module tb_readback_hub;
   import yabot_bus_pkg::*;

   localparam int N_CH   = 6;
   localparam int DATA_W = 28;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 4;
`ifdef READBACK_HUB_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [N_CH*DATA_W-1:0] ch_data = '0;
   logic [N_CH-1:0]        ch_wr = '0;
   logic [N_CH-1:0]        ch_rdy;
   logic [DATA_W-1:0]      out_data;
   logic [ADDR_W-1:0]      out_addr;
   logic                   out_valid;
   logic                   out_rdy = 1'b0;
   logic [N_CH-1:0]        ovf;
   logic [N_CH-1:0]        ovf_clr = '0;

   int checks = 0;
   int errors = 0;

   readback_hub #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                  .FIFO_DEPTH(DEPTH), .CH_BASE(0)) dut (
      .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .ch_wr(ch_wr), .ch_rdy(ch_rdy),
      .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_rdy(out_rdy),
      .ovf(ovf), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] word(input int ch, input int k);
      rb_word_t w;
      w.ctrl = 4'(ch);
      w.data = 24'(k * 24'h010101 + ch);
      return w;
   endfunction

   // Reference model: one queue per channel plus the word on the output.
   logic [DATA_W-1:0] mq [N_CH][$];
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic [ADDR_W-1:0] m_addr;
   int                m_ptr;
   logic [N_CH-1:0]   m_ovf, m_rdy;

   task automatic model_reset();
      for (int i = 0; i < N_CH; i++) mq[i].delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_addr  = '0;
      m_ptr   = 0;
      m_ovf   = '0;
      m_rdy   = '1;
   endtask

   task automatic model_step();
      int g;
      logic [N_CH-1:0] drops;
      if (!m_valid || out_rdy) begin
         g = -1;
         if (PRIO && mq[0].size() > 0) g = 0;
         for (int k = 0; k < N_CH; k++) begin
            int c;
            c = (m_ptr + k) % N_CH;
            if (g < 0 && !(PRIO && c == 0) && mq[c].size() > 0) g = c;
         end
         if (g >= 0) begin
            m_data  = mq[g].pop_front();
            m_addr  = ADDR_W'(g);
            m_valid = 1'b1;
            if (!(PRIO && g == 0)) m_ptr = (g + 1) % N_CH;
         end else begin
            m_valid = 1'b0;
         end
      end
      drops = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (ch_wr[i]) begin
            if (mq[i].size() < DEPTH) mq[i].push_back(ch_data[i*DATA_W +: DATA_W]);
            else drops[i] = 1'b1;
         end
      end
      m_ovf = (m_ovf & ~ovf_clr) | drops;
      for (int i = 0; i < N_CH; i++) m_rdy[i] = (mq[i].size() != DEPTH);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else model_step();
      #1;
      check("model_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
         check("model_data", 32'(out_data), 32'(m_data));
         check("model_addr", 32'(out_addr), 32'(m_addr));
      end
      check("model_rdy", 32'(ch_rdy), 32'(m_rdy));
      check("model_ovf", 32'(ovf), 32'(m_ovf));
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic set_ch(input int ch, input logic [DATA_W-1:0] w);
      ch_data[ch*DATA_W +: DATA_W] = w;
      ch_wr[ch] = 1'b1;
   endtask

   int push_at [$];
   int lat;

   initial begin
      repeat (3) tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_rdy", 32'(ch_rdy), 32'h3f);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_addr", 32'(out_addr), 32'd0);
      rst_n = 1'b1;

      // single push, two-cycle latency
      set_ch(3, 28'h0123456);
      tick();
      ch_wr = '0;
      check("t1_lat1_valid", 32'(out_valid), 32'd0);
      tick();
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_addr", 32'(out_addr), 32'd3);
      check("t1_data", 32'(out_data), 32'h0123456);
      out_rdy = 1'b1;
      tick();
      check("t1_drained", 32'(out_valid), 32'd0);

      // all channels at once, twice
      do_reset();
      out_rdy = 1'b1;
      for (int r = 1; r <= 2; r++) begin
         for (int i = 0; i < N_CH; i++) set_ch(i, word(i, r));
         tick();
         ch_wr = '0;
         check("t2_gap", 32'(out_valid), 32'd0);
         for (int i = 0; i < N_CH; i++) begin
            tick();
            check("t2_valid", 32'(out_valid), 32'd1);
            check("t2_addr", 32'(out_addr), 32'(i));
            check("t2_data", 32'(out_data), 32'(word(i, r)));
         end
         tick();
         check("t2_end", 32'(out_valid), 32'd0);
      end

      // stalled sink, overflow on channel 2
      out_rdy = 1'b0;
      for (int k = 0; k < 6; k++) begin
         set_ch(2, word(2, 10 + k));
         tick();
      end
      ch_wr = '0;
      check("t3_rdy2", 32'(ch_rdy[2]), 32'd0);
      check("t3_ovf2", 32'(ovf[2]), 32'd1);
      check("t3_hold", 32'(out_data), 32'(word(2, 10)));
      ovf_clr = 6'b000100;
      tick();
      ovf_clr = '0;
      check("t3_ovf_clr", 32'(ovf[2]), 32'd0);
      check("t3_hold2", 32'(out_data), 32'(word(2, 10)));
      out_rdy = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("t3_drain", 32'(out_data), 32'(word(2, 10 + k)));
      end
      tick();
      check("t3_empty", 32'(out_valid), 32'd0);

      // full FIFO with simultaneous push and pop
      out_rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         set_ch(1, word(1, 20 + k));
         tick();
      end
      ch_wr = '0;
      check("t4_full", 32'(ch_rdy[1]), 32'd0);
      set_ch(1, word(1, 25));
      out_rdy = 1'b1;
      tick();
      ch_wr = '0;
      check("t4_no_ovf", 32'(ovf[1]), 32'd0);
      check("t4_still_full", 32'(ch_rdy[1]), 32'd0);
      check("t4_first", 32'(out_data), 32'(word(1, 21)));
      for (int k = 22; k <= 25; k++) begin
         tick();
         check("t4_order", 32'(out_data), 32'(word(1, k)));
      end
      tick();
      check("t4_empty", 32'(out_valid), 32'd0);

      // status channel against a busy channel 4
      do_reset();
      out_rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         set_ch(4, word(4, 30 + k));
         tick();
      end
      ch_wr = '0;
      for (int i = 0; i < 14; i++) begin
         if (out_valid && out_addr == 4'(CH_STATUS) && push_at.size() > 0) begin
            lat = i - push_at.pop_front();
            check("t5_ch0_wait", 32'(lat <= 3), 32'd1);
         end
         out_rdy = 1'b1;
         ch_wr = '0;
         if (i < 12 && i % 2 == 0) begin
            set_ch(CH_STATUS, word(0, 40 + i));
            push_at.push_back(i);
         end
         tick();
      end
      check("t5_ch0_served", 32'(push_at.size()), 32'd0);

      // asynchronous reset in the middle of a burst
      out_rdy = 1'b0;
      for (int k = 0; k < 6; k++) begin
         set_ch(5, word(5, 50 + k));
         if (k == 5) for (int i = 0; i < 5; i++) set_ch(i, word(i, 55));
         tick();
      end
      ch_wr = '0;
      check("t6_ovf5", 32'(ovf[5]), 32'd1);
      out_rdy = 1'b1;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_valid", 32'(out_valid), 32'd0);
      check("t6_async_rdy", 32'(ch_rdy), 32'h3f);
      check("t6_async_ovf", 32'(ovf), 32'd0);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t6_no_stale", 32'(out_valid), 32'd0);
      end
      set_ch(3, word(3, 60));
      tick();
      ch_wr = '0;
      tick();
      check("t6_new_valid", 32'(out_valid), 32'd1);
      check("t6_new_data", 32'(out_data), 32'(word(3, 60)));
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
